instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning instruction address width, equal to the program counter width.
REQ-002 SHALL have parameter INSTR_W, default 8, meaning instruction word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pc  input  ADDR_W  current program counter value.
REQ-006 SHALL have port pc_enable  output  1  one-cycle increment request to the program counter.
REQ-007 SHALL have port pc_load  output  1  one-cycle load request to the program counter.
REQ-008 SHALL have port pc_load_addr  output  ADDR_W  address to load into the program counter.
REQ-009 SHALL have port mem_req  output  1  instruction memory read request.
REQ-010 SHALL have port mem_addr  output  ADDR_W  instruction memory read address.
REQ-011 SHALL have port mem_ready  input  1  read data valid; completes the request.
REQ-012 SHALL have port mem_rdata  input  INSTR_W  instruction memory read data.
REQ-013 SHALL have port instr_valid  output  1  instr and instr_addr hold a fetched instruction.
REQ-014 SHALL have port instr_ready  input  1  decoder accepts the instruction.
REQ-015 SHALL have port instr  output  INSTR_W  fetched instruction word.
REQ-016 SHALL have port instr_addr  output  ADDR_W  address the instruction was fetched from.
REQ-017 SHALL have port redirect  input  1  jump request; highest priority.
REQ-018 SHALL have port redirect_addr  input  ADDR_W  jump target.
REQ-019 SHALL have port halt  input  1  stop issuing new fetches.

Function
REQ-020 SHALL implement FSM states IDLE, FETCH, HOLD; IDLE->FETCH when halt=0.
REQ-021 In FETCH SHALL drive mem_req=1 and mem_addr=pc, keeping both stable until mem_ready=1; a request is never withdrawn.
REQ-022 On FETCH with mem_ready=1 and redirect=0, SHALL assert pc_enable combinationally in that cycle, register instr<=mem_rdata and instr_addr<=pc, and go to HOLD.
REQ-023 In HOLD SHALL drive instr_valid=1 with instr and instr_addr stable until instr_ready=1.
REQ-024 On HOLD with instr_ready=1 SHALL go to IDLE if halt=1, else to FETCH.
REQ-025 On redirect=1 in any state SHALL assert pc_load=1, pc_load_addr=redirect_addr in that cycle, suppress pc_enable, discard any mem_rdata returned that cycle, and clear instr_valid next cycle.
REQ-026 After redirect SHALL go to FETCH if halt=0, else to IDLE; the next mem_addr equals redirect_addr.
REQ-027 Redirect together with the HOLD handshake (instr_ready=1) SHALL count as the instruction consumed, then redirect.
REQ-028 Redirect with FETCH outstanding SHALL keep mem_req=1 and re-present mem_addr=pc on the next cycle; the response in the redirect cycle is dropped.
REQ-029 halt=1 during FETCH SHALL not abort the outstanding request; it takes effect when leaving HOLD.
REQ-030 pc_enable and pc_load SHALL never be high in the same cycle.
REQ-031 Address arithmetic SHALL wrap modulo 2^ADDR_W, so the fetch after 4'hF is 4'h0.
REQ-032 Without PREFETCH_EN, throughput SHALL be at most one instruction per 2 cycles.

Reset
REQ-033 On rst_n=0 SHALL immediately enter IDLE with instr_valid=0, instr=0, instr_addr=0, mem_req=0, pc_enable=0, pc_load=0, pc_load_addr=0.
REQ-034 Reset during an outstanding fetch SHALL abandon it; a mem_ready arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-035 With macro INSTR_FETCH_PREFETCH_EN defined, SHALL add a one-entry prefetch buffer: in HOLD, fetch pc into the buffer and assert pc_enable on its completion; on consume, buffer contents move to instr/instr_valid the next cycle, sustaining one instruction per cycle when mem_ready is held high.
REQ-036 With INSTR_FETCH_PREFETCH_EN defined, redirect SHALL also invalidate the buffer, and halt SHALL block new prefetches.
REQ-037 Without INSTR_FETCH_PREFETCH_EN, no buffer logic SHALL be present and REQ-032 applies.

Verification
REQ-038 Reset, halt=0, mem_ready=1, mem_rdata=8'hA5 at pc=0 -> mem_req cycle 1, pc_enable pulse, instr=8'hA5, instr_addr=0, instr_valid next cycle.
REQ-039 instr_ready=0 for 5 cycles in HOLD -> instr and instr_valid stable; no mem_req (no prefetch) and no pc_enable.
REQ-040 Redirect to 4'h9 in the same cycle as mem_ready -> pc_load=1, pc_enable=0, data dropped, next mem_addr=4'h9.
REQ-041 pc=4'hF with continuous mem_ready -> instr_addr 4'hF then 4'h0.
REQ-042 rst_n low mid-FETCH, with mem_ready=1 one cycle after release -> instr_valid stays 0, pc_enable 0.
REQ-043 Build with INSTR_FETCH_PREFETCH_EN, instr_ready=1, mem_ready=1 -> instr_valid high every cycle and instr_addr 0,1,2,3.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: single-issue instruction fetch FSM between program counter, instruction memory and decoder.
// Define INSTR_FETCH_PREFETCH_EN to add a one-entry prefetch buffer for one-instruction-per-cycle throughput.
module instr_fetch #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_enable,
  output logic               pc_load,
  output logic [ADDR_W-1:0]  pc_load_addr,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               halt
);

  // state | meaning
  // IDLE  | no request; leaves when halt drops
  // FETCH | mem_req held at pc until mem_ready
  // HOLD  | instr_valid held until instr_ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;
  logic   done;
  logic   pending;
  logic   hold_req;

  assign mem_req      = (state == FETCH) || hold_req;
  assign mem_addr     = pc;
  assign done         = mem_req && mem_ready && !redirect;
  assign pending      = mem_req && !mem_ready;
  // A redirect wins over a completing fetch, so the two pc requests are exclusive.
  assign pc_enable    = rst_n && done;
  assign pc_load      = rst_n && redirect;
  assign pc_load_addr = pc_load ? redirect_addr : '0;

`ifdef INSTR_FETCH_PREFETCH_EN
  logic               pf_out;
  logic               pf_valid;
  logic [INSTR_W-1:0] pf_data;
  logic [ADDR_W-1:0]  pf_addr;

  // An issued prefetch stays up until it completes, even if halt rises meanwhile.
  assign hold_req = (state == HOLD) && (pf_out || (!pf_valid && !halt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_addr  <= '0;
      pf_out      <= 1'b0;
      pf_valid    <= 1'b0;
      pf_data     <= '0;
      pf_addr     <= '0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
      pf_valid    <= 1'b0;
      pf_out      <= 1'b0;
      state       <= (pending || !halt) ? FETCH : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!halt) state <= FETCH;
        end
        FETCH: begin
          pf_out <= 1'b0;
          if (mem_ready) begin
            instr       <= mem_rdata;
            instr_addr  <= pc;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (done) begin
            pf_out <= 1'b0;
            if (instr_ready) begin
              instr      <= mem_rdata;
              instr_addr <= pc;
            end else begin
              pf_valid <= 1'b1;
              pf_data  <= mem_rdata;
              pf_addr  <= pc;
            end
          end else if (instr_ready) begin
            if (pf_valid) begin
              instr      <= pf_data;
              instr_addr <= pf_addr;
              pf_valid   <= 1'b0;
              pf_out     <= 1'b0;
            end else begin
              // An unfinished prefetch carries on as a plain fetch of the same pc.
              instr_valid <= 1'b0;
              pf_out      <= 1'b0;
              state       <= (hold_req || !halt) ? FETCH : IDLE;
            end
          end else begin
            pf_out <= hold_req;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign hold_req = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_addr  <= '0;
    end else if (redirect) begin
      // An outstanding request is never withdrawn, even under halt.
      instr_valid <= 1'b0;
      state       <= (pending || !halt) ? FETCH : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!halt) state <= FETCH;
        end
        FETCH: begin
          if (mem_ready) begin
            instr       <= mem_rdata;
            instr_addr  <= pc;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= halt ? IDLE : FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic against a flag-level model.
module tb_instr_fetch;
  localparam int AW = 4;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] pc;
  logic          pc_enable;
  logic          pc_load;
  logic [AW-1:0] pc_load_addr;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic [IW-1:0] mem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_addr;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          halt;

  instr_fetch #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .pc_enable     (pc_enable),
    .pc_load       (pc_load),
    .pc_load_addr  (pc_load_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_addr    (instr_addr),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt          (halt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Model: a fetch is wanted/outstanding (m_req), or an instruction is held (m_valid), or neither (idle).
  bit            use_model = 1'b1;
  bit            m_req;
  bit            m_valid;
  logic [IW-1:0] m_instr;
  logic [AW-1:0] m_iaddr;
  logic [AW-1:0] next_pc;

  task automatic step(input bit h, input bit mr, input logic [IW-1:0] rd,
                      input bit ir, input bit rdir, input logic [AW-1:0] ra);
    bit exp_en;
    @(negedge clk);
    pc            = next_pc;
    halt          = h;
    mem_ready     = mr;
    mem_rdata     = rd;
    instr_ready   = ir;
    redirect      = rdir;
    redirect_addr = ra;
    #1;
    check("pc_excl", 32'(pc_enable & pc_load), 32'd0);
    if (use_model) begin
      exp_en = m_req && mr && !rdir;
      check("mem_req", 32'(mem_req), 32'(m_req));
      if (m_req) check("mem_addr", 32'(mem_addr), 32'(pc));
      check("pc_enable", 32'(pc_enable), 32'(exp_en));
      check("pc_load", 32'(pc_load), 32'(rdir));
      if (rdir) check("pc_load_addr", 32'(pc_load_addr), 32'(ra));
      check("instr_valid", 32'(instr_valid), 32'(m_valid));
      if (m_valid) begin
        check("instr", 32'(instr), 32'(m_instr));
        check("instr_addr", 32'(instr_addr), 32'(m_iaddr));
      end
      if (rdir) begin
        m_valid = 1'b0;
        m_req   = (m_req && !mr) || !h;
      end else if (m_req && mr) begin
        m_valid = 1'b1;
        m_instr = rd;
        m_iaddr = pc;
        m_req   = 1'b0;
      end else if (m_valid && ir) begin
        m_valid = 1'b0;
        m_req   = !h;
      end else if (!m_valid && !m_req) begin
        m_req = !h;
      end
      next_pc = rdir ? ra : (exp_en ? pc + 4'd1 : pc);
    end else begin
      next_pc = pc_load ? pc_load_addr : (pc_enable ? pc + 4'd1 : pc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n         = 1'b0;
    halt          = 1'b1;
    mem_ready     = 1'b0;
    mem_rdata     = '0;
    instr_ready   = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    #1;
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_addr", 32'(instr_addr), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_pc_enable", 32'(pc_enable), 32'd0);
    check("rst_pc_load", 32'(pc_load), 32'd0);
    check("rst_pc_load_addr", 32'(pc_load_addr), 32'd0);
    #1;
    rst_n   = 1'b1;
    m_req   = 1'b0;
    m_valid = 1'b0;
    m_instr = '0;
    m_iaddr = '0;
    pc      = '0;
    next_pc = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] seen[$];
    rst_n = 1'b1;
    pc    = '0;
`ifdef INSTR_FETCH_PREFETCH_EN
    use_model = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b1, 1'b0, 4'h0);
      if (i >= 2) begin
        check("pf_valid", 32'(instr_valid), 32'd1);
        check("pf_addr", 32'(instr_addr), 32'(i - 2));
      end
    end
`else
    do_reset();
    // First fetch after reset: IDLE cycle, then request at pc 0.
    step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 4'h0);
    check("first_idle_req", 32'(mem_req), 32'd0);
    step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 4'h0);
    check("first_req", 32'(mem_req), 32'd1);
    check("first_pc_en", 32'(pc_enable), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 4'h0);
      check("hold_instr", 32'(instr), 32'hA5);
      check("hold_addr", 32'(instr_addr), 32'd0);
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_no_req", 32'(mem_req), 32'd0);
      check("hold_no_pc_en", 32'(pc_enable), 32'd0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'h0);
    // Redirect coinciding with the memory response.
    step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 4'h9);
    check("redir_pc_load", 32'(pc_load), 32'd1);
    check("redir_pc_en", 32'(pc_enable), 32'd0);
    check("redir_load_addr", 32'(pc_load_addr), 32'h9);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    check("redir_next_req", 32'(mem_req), 32'd1);
    check("redir_next_addr", 32'(mem_addr), 32'h9);
    check("redir_dropped", 32'(instr_valid), 32'd0);
    step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    check("redir_instr", 32'(instr), 32'h77);
    check("redir_iaddr", 32'(instr_addr), 32'h9);
    // Wrap from 4'hF to 4'h0; redirect together with consume.
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'hF);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 4'h0);
      if (instr_valid) seen.push_back(instr_addr);
    end
    check("wrap_count", 32'(seen.size() >= 2), 32'd1);
    if (seen.size() >= 2) begin
      check("wrap_first", 32'(seen[0]), 32'hF);
      check("wrap_second", 32'(seen[1]), 32'h0);
    end
    // Reset in the middle of an outstanding fetch.
    for (int i = 0; i < 4 && !mem_req; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'h0);
    check("midfetch_req", 32'(mem_req), 32'd1);
    do_reset();
    step(1'b0, 1'b1, 8'hE1, 1'b1, 1'b0, 4'h0);
    check("post_rst_valid", 32'(instr_valid), 32'd0);
    check("post_rst_pc_en", 32'(pc_enable), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    check("post_rst_valid2", 32'(instr_valid), 32'd0);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      step(($urandom_range(0, 7) == 0), bit'($urandom_range(0, 1)), 8'($urandom),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), 4'($urandom));
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
